// File: rtl/had_bkpt_pkg.sv
// Shared definitions for the HAD breakpoint controller: register indices,
// FSM state encoding and STATUS field offsets.
package had_bkpt_pkg;

   localparam logic [3:0] REG_CTRL    = 4'h0;
   localparam logic [3:0] REG_CNT     = 4'h1;
   localparam logic [3:0] REG_STATUS  = 4'h2;
   localparam logic [3:0] REG_CH_BASE = 4'h4;

   localparam int CTRL_TYPE_LSB    = 8;
   localparam int STATUS_HITID_LSB = 16;
   localparam int STATUS_BUSY_BIT  = 24;
   localparam int HITID_W          = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_REQ   = 2'd2,
      ST_DBG   = 2'd3
   } bkpt_state_t;

endpackage

// File: rtl/had_bkpt_prio_enc.sv
// Lowest-index priority encoder: returns the index of the lowest set bit
// of the hit vector (0 when no bit is set).
module had_bkpt_prio_enc
   import had_bkpt_pkg::*;
#(
   parameter int N = 2
) (
   input  logic [N-1:0]       i_hits,
   output logic [HITID_W-1:0] o_idx
);

   // Scan from the top down so the lowest hitting index is the last to win.
   always_comb begin
      o_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_hits[i]) o_idx = HITID_W'(i);
      end
   end

endmodule

// File: rtl/had_bkpt_ctrl.sv
// HAD breakpoint controller: channel configuration, hit qualification,
// optional match counter (HAD_BKPT_CNT_EN) and debug-request handshake.
module had_bkpt_ctrl
   import had_bkpt_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 8
) (
   input  logic                 forever_cpuclk,
   input  logic                 hadrst,
   input  logic                 cfg_wen,
   input  logic [3:0]           cfg_addr,
   input  logic [31:0]          cfg_wdata,
   output logic [31:0]          cfg_rdata,
   output logic [NUM_CH*32-1:0] ch_addr,
   output logic [NUM_CH-1:0]    ch_en,
   output logic [NUM_CH-1:0]    ch_type,
   input  logic [NUM_CH-1:0]    ch_inst_hit,
   input  logic [NUM_CH-1:0]    ch_mem_hit,
   input  logic                 iu_yy_xx_dbgon,
   output logic                 had_core_dbg_mode_req,
   output logic                 bkpt_busy
);

   bkpt_state_t          r_state;
   bkpt_state_t          w_next_state;
   logic [NUM_CH-1:0]    r_en;
   logic [NUM_CH-1:0]    r_type;
   logic [NUM_CH-1:0]    r_status;
   logic [NUM_CH*32-1:0] r_addr;
   logic [HITID_W-1:0]   r_hitid;
   logic                 r_req;
   logic [NUM_CH-1:0]    w_qhit;
   logic [NUM_CH-1:0]    w_status_clr;
   logic [HITID_W-1:0]   w_hitid;
   logic [CNT_W-1:0]     w_cnt_val;
   logic                 w_event;
   logic                 w_cnt_zero;
   logic                 w_break;
   logic                 w_wr_ctrl;
   logic                 w_wr_status;

   assign w_qhit       = r_en & ((r_type & ch_mem_hit) | (~r_type & ch_inst_hit));
   assign w_event      = |w_qhit;
   assign w_wr_ctrl    = cfg_wen && (cfg_addr == REG_CTRL);
   assign w_wr_status  = cfg_wen && (cfg_addr == REG_STATUS);
   assign w_status_clr = w_wr_status ? cfg_wdata[NUM_CH-1:0] : '0;
   assign w_cnt_zero   = (w_cnt_val == '0);

   had_bkpt_prio_enc #(.N(NUM_CH)) u_prio_enc (
      .i_hits (w_qhit),
      .o_idx  (w_hitid)
   );

`ifdef HAD_BKPT_CNT_EN
   logic [CNT_W-1:0] r_cnt;
   logic             w_wr_cnt;
   logic             w_dec;

   assign w_wr_cnt = cfg_wen && (cfg_addr == REG_CNT);
   assign w_dec    = (r_state == ST_ARMED) && w_event && !iu_yy_xx_dbgon && !w_cnt_zero;

   // A register write takes precedence over a same-cycle decrement.
   always_ff @(posedge forever_cpuclk or posedge hadrst) begin
      if (hadrst) begin
         r_cnt <= '0;
      end else if (w_wr_cnt) begin
         r_cnt <= cfg_wdata[CNT_W-1:0];
      end else if (w_dec) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign w_cnt_val = r_cnt;
`else
   assign w_cnt_val = '0;
`endif

   always_comb begin
      w_next_state = r_state;
      w_break      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (|r_en) w_next_state = ST_ARMED;
         end
         ST_ARMED: begin
            if (!(|r_en)) begin
               w_next_state = ST_IDLE;
            end else if (w_event && !iu_yy_xx_dbgon && w_cnt_zero) begin
               w_next_state = ST_REQ;
               w_break      = 1'b1;
            end
         end
         ST_REQ: begin
            if (iu_yy_xx_dbgon) w_next_state = ST_DBG;
         end
         ST_DBG: begin
            if (!iu_yy_xx_dbgon) w_next_state = (|r_en) ? ST_ARMED : ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // A new hit on a bit beats a same-cycle write-1-to-clear of that bit.
   always_ff @(posedge forever_cpuclk or posedge hadrst) begin
      if (hadrst) begin
         r_state  <= ST_IDLE;
         r_req    <= 1'b0;
         r_hitid  <= '0;
         r_status <= '0;
      end else begin
         r_state  <= w_next_state;
         r_req    <= (w_next_state == ST_REQ);
         r_status <= (r_status & ~w_status_clr) | (w_break ? w_qhit : '0);
         if (w_break) r_hitid <= w_hitid;
      end
   end

   always_ff @(posedge forever_cpuclk or posedge hadrst) begin
      if (hadrst) begin
         r_en   <= '0;
         r_type <= '0;
         r_addr <= '0;
      end else if (cfg_wen) begin
         if (w_wr_ctrl) begin
            r_en   <= cfg_wdata[NUM_CH-1:0];
            r_type <= cfg_wdata[CTRL_TYPE_LSB +: NUM_CH];
         end
         for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_addr == REG_CH_BASE + 4'(i)) r_addr[32*i +: 32] <= cfg_wdata;
         end
      end
   end

   always_comb begin
      cfg_rdata = '0;
      case (cfg_addr)
         REG_CTRL: begin
            cfg_rdata[NUM_CH-1:0]              = r_en;
            cfg_rdata[CTRL_TYPE_LSB +: NUM_CH] = r_type;
         end
         REG_CNT: cfg_rdata[CNT_W-1:0] = w_cnt_val;
         REG_STATUS: begin
            cfg_rdata[NUM_CH-1:0]                   = r_status;
            cfg_rdata[STATUS_HITID_LSB +: HITID_W]  = r_hitid;
            cfg_rdata[STATUS_BUSY_BIT]              = bkpt_busy;
         end
         default: begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (cfg_addr == REG_CH_BASE + 4'(i)) cfg_rdata = r_addr[32*i +: 32];
            end
         end
      endcase
   end

   assign ch_addr               = r_addr;
   assign ch_en                 = r_en;
   assign ch_type               = r_type;
   assign had_core_dbg_mode_req = r_req;
   assign bkpt_busy             = (r_state == ST_REQ) || (r_state == ST_DBG);

endmodule

// File: tb/tb_had_bkpt_ctrl.sv
// Self-checking bench for had_bkpt_ctrl: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_had_bkpt_ctrl;

   localparam int NCH = 2;

   logic           clk;
   logic           rst;
   logic           cfgWen;
   logic [3:0]     cfgAddr;
   logic [31:0]    cfgWdata;
   logic [31:0]    cfgRdata;
   logic [NCH*32-1:0] chAddr;
   logic [NCH-1:0] chEn;
   logic [NCH-1:0] chType;
   logic [NCH-1:0] instHit;
   logic [NCH-1:0] memHit;
   logic           dbgon;
   logic           dbgReq;
   logic           busy;

   int nChecks = 0;
   int nErrors = 0;

   had_bkpt_ctrl #(.NUM_CH(NCH), .CNT_W(8)) dut (
      .forever_cpuclk        (clk),
      .hadrst                (rst),
      .cfg_wen               (cfgWen),
      .cfg_addr              (cfgAddr),
      .cfg_wdata             (cfgWdata),
      .cfg_rdata             (cfgRdata),
      .ch_addr               (chAddr),
      .ch_en                 (chEn),
      .ch_type               (chType),
      .ch_inst_hit           (instHit),
      .ch_mem_hit            (memHit),
      .iu_yy_xx_dbgon        (dbgon),
      .had_core_dbg_mode_req (dbgReq),
      .bkpt_busy             (busy)
   );

   // Free-running core clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wen;
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic [1:0]  inst;
      logic [1:0]  mem;
      logic        dbg;
      logic        expReq;
      logic        expBusy;
      logic [31:0] expRdata;
   } vec_t;

   vec_t vecs[$];

`ifdef HAD_BKPT_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   // Behavioural model state (reset values).
   logic [NCH-1:0] mEn, mTyp, mStatus;
   logic [31:0]    mAddr [NCH];
   int             mCnt, mHitid;
   bit             mArmed, mReq, mDbg;

   function automatic vec_t mk(input logic wen, input logic [3:0] addr, input logic [31:0] wdata,
                               input logic [1:0] inst, input logic [1:0] mem, input logic dbg,
                               input logic eReq, input logic eBusy, input logic [31:0] eRd);
      vec_t v;
      v.wen = wen; v.addr = addr; v.wdata = wdata; v.inst = inst; v.mem = mem; v.dbg = dbg;
      v.expReq = eReq; v.expBusy = eBusy; v.expRdata = eRd;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic wen, input logic [3:0] addr, input logic [31:0] wdata,
                                input logic [1:0] inst, input logic [1:0] mem, input logic dbg);
      cfgWen = wen; cfgAddr = addr; cfgWdata = wdata;
      instHit = inst; memHit = mem; dbgon = dbg;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] modelRead(input logic [3:0] a);
      logic [31:0] r;
      r = '0;
      if (a == 4'h0) r = {16'h0, 6'h0, mTyp, 6'h0, mEn};
      else if (a == 4'h1) r = CNT_EN ? 32'(mCnt) : 32'h0;
      else if (a == 4'h2) r = {7'h0, 1'(mReq || mDbg), 5'h0, 3'(mHitid), 14'h0, mStatus};
      else if (a >= 4'h4 && int'(a) < 4 + NCH) r = mAddr[int'(a) - 4];
      return r;
   endfunction

   task automatic modelReset();
      mEn = '0; mTyp = '0; mStatus = '0; mCnt = 0; mHitid = 0;
      mArmed = 0; mReq = 0; mDbg = 0;
      for (int i = 0; i < NCH; i++) mAddr[i] = '0;
   endtask

   // One clock of the controller's rules, evaluated on pre-edge values.
   task automatic modelStep(input logic wen, input logic [3:0] a, input logic [31:0] d,
                            input logic [1:0] inst, input logic [1:0] mem, input logic dbg);
      logic [NCH-1:0] q, setv, clr;
      q = mEn & ((mTyp & mem) | (~mTyp & inst));
      setv = '0;
      if (mReq) begin
         if (dbg) begin mReq = 0; mDbg = 1; end
      end else if (mDbg) begin
         if (!dbg) begin mDbg = 0; mArmed = (mEn != 0); end
      end else begin
         if (mArmed && q != 0 && !dbg) begin
            if (mCnt == 0) begin
               mReq = 1;
               setv = q;
               for (int i = NCH - 1; i >= 0; i--) if (q[i]) mHitid = i;
            end else begin
               mCnt = mCnt - 1;
            end
         end
         mArmed = !mReq && (mEn != 0);
      end
      clr = (wen && a == 4'h2) ? d[NCH-1:0] : '0;
      mStatus = (mStatus & ~clr) | setv;
      if (wen) begin
         if (a == 4'h0) begin mEn = d[NCH-1:0]; mTyp = d[8 +: NCH]; end
         if (a == 4'h1 && CNT_EN) mCnt = int'(d[7:0]);
         if (a >= 4'h4 && int'(a) < 4 + NCH) mAddr[int'(a) - 4] = d;
      end
   endtask

   initial begin
      int breakAt;
      logic [3:0] addrPool [7];
      bit reqSeen;
      addrPool = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h3, 4'h9};

      rst = 1'b1;
      applyStimulus(0, 4'h0, 32'h0, 2'b00, 2'b00, 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      #1;

      checkOutput("reset req", 64'(dbgReq), 64'h0);
      checkOutput("reset busy", 64'(busy), 64'h0);
      checkOutput("reset ch_en", 64'(chEn), 64'h0);
      checkOutput("reset ch_type", 64'(chType), 64'h0);
      checkOutput("reset ch_addr", 64'(chAddr), 64'h0);
      for (int a = 0; a < 6; a++) begin
         cfgAddr = 4'(a);
         #1 checkOutput($sformatf("reset rdata[%0d]", a), 64'(cfgRdata), 64'h0);
      end

      vecs.push_back(mk(1, 4'h4, 32'h0000_1000, 2'b00, 2'b00, 0, 0, 0, 32'h0000_1000));
      vecs.push_back(mk(1, 4'h0, 32'h0000_0001, 2'b00, 2'b00, 0, 0, 0, 32'h0000_0001));
      vecs.push_back(mk(0, 4'h0, 32'h0,         2'b00, 2'b00, 0, 0, 0, 32'h0000_0001));
      vecs.push_back(mk(0, 4'h2, 32'h0,         2'b01, 2'b00, 0, 1, 1, 32'h0100_0001));
      vecs.push_back(mk(0, 4'h2, 32'h0,         2'b00, 2'b00, 1, 0, 1, 32'h0100_0001));
      vecs.push_back(mk(0, 4'h2, 32'h0,         2'b00, 2'b00, 0, 0, 0, 32'h0000_0001));
      vecs.push_back(mk(1, 4'h2, 32'h0000_0001, 2'b00, 2'b00, 0, 0, 0, 32'h0000_0000));
      vecs.push_back(mk(1, 4'h0, 32'h0000_0303, 2'b00, 2'b00, 0, 0, 0, 32'h0000_0303));
      vecs.push_back(mk(0, 4'h2, 32'h0,         2'b00, 2'b11, 0, 1, 1, 32'h0100_0003));
      vecs.push_back(mk(0, 4'h2, 32'h0,         2'b00, 2'b00, 1, 0, 1, 32'h0100_0003));
      vecs.push_back(mk(0, 4'h2, 32'h0,         2'b00, 2'b00, 0, 0, 0, 32'h0000_0003));
      vecs.push_back(mk(1, 4'h2, 32'h0000_0003, 2'b00, 2'b00, 0, 0, 0, 32'h0000_0000));
      vecs.push_back(mk(1, 4'h0, 32'h0000_0001, 2'b00, 2'b00, 0, 0, 0, 32'h0000_0001));
      vecs.push_back(mk(0, 4'h2, 32'h0,         2'b00, 2'b01, 0, 0, 0, 32'h0000_0000));
      vecs.push_back(mk(1, 4'h0, 32'h0000_0003, 2'b00, 2'b00, 0, 0, 0, 32'h0000_0003));
      vecs.push_back(mk(0, 4'h2, 32'h0,         2'b10, 2'b00, 0, 1, 1, 32'h0101_0002));
      vecs.push_back(mk(0, 4'h2, 32'h0,         2'b00, 2'b00, 1, 0, 1, 32'h0101_0002));
      vecs.push_back(mk(1, 4'h0, 32'h0,         2'b00, 2'b00, 1, 0, 1, 32'h0000_0000));
      vecs.push_back(mk(0, 4'h0, 32'h0,         2'b00, 2'b00, 0, 0, 0, 32'h0000_0000));
      vecs.push_back(mk(1, 4'h3, 32'hFFFF_FFFF, 2'b00, 2'b00, 0, 0, 0, 32'h0000_0000));
      vecs.push_back(mk(1, 4'h5, 32'hDEAD_BEEF, 2'b00, 2'b00, 0, 0, 0, 32'hDEAD_BEEF));
      vecs.push_back(mk(1, 4'h6, 32'h1234_5678, 2'b00, 2'b00, 0, 0, 0, 32'h0000_0000));
      vecs.push_back(mk(1, 4'hF, 32'hFFFF_FFFF, 2'b00, 2'b00, 0, 0, 0, 32'h0000_0000));
      vecs.push_back(mk(0, 4'h4, 32'h0,         2'b00, 2'b00, 0, 0, 0, 32'h0000_1000));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].inst, vecs[i].mem, vecs[i].dbg);
         tick();
         checkOutput($sformatf("vec%0d req", i), 64'(dbgReq), 64'(vecs[i].expReq));
         checkOutput($sformatf("vec%0d busy", i), 64'(busy), 64'(vecs[i].expBusy));
         checkOutput($sformatf("vec%0d rdata", i), 64'(cfgRdata), 64'(vecs[i].expRdata));
      end
      checkOutput("ch_addr after table", 64'(chAddr), {32'hDEAD_BEEF, 32'h0000_1000});

      // Event while the core is already in debug mode is ignored.
      applyStimulus(1, 4'h0, 32'h1, 2'b00, 2'b00, 0); tick();
      applyStimulus(0, 4'h0, 32'h0, 2'b00, 2'b00, 0); tick();
      checkOutput("ch_en after enable", 64'(chEn), 64'h1);
      applyStimulus(0, 4'h2, 32'h0, 2'b01, 2'b00, 1); tick();
      checkOutput("dbgon-high hit req", 64'(dbgReq), 64'h0);
      checkOutput("dbgon-high hit busy", 64'(busy), 64'h0);
      applyStimulus(0, 4'h2, 32'h0, 2'b00, 2'b00, 0); tick();

      // STATUS clear and new set in the same cycle: the set wins.
      applyStimulus(1, 4'h2, 32'h3, 2'b01, 2'b00, 0); tick();
      checkOutput("clr+set req", 64'(dbgReq), 64'h1);
      checkOutput("clr+set status", 64'(cfgRdata), 64'h0100_0001);
      applyStimulus(0, 4'h2, 32'h0, 2'b00, 2'b00, 1); tick();
      applyStimulus(0, 4'h2, 32'h0, 2'b00, 2'b00, 0); tick();

      // Clearing enables in REQ does not cancel the request; exit goes to IDLE.
      applyStimulus(0, 4'h2, 32'h0, 2'b01, 2'b00, 0); tick();
      checkOutput("req before ctrl clear", 64'(dbgReq), 64'h1);
      applyStimulus(1, 4'h0, 32'h0, 2'b00, 2'b00, 0); tick();
      checkOutput("req held after ctrl clear", 64'(dbgReq), 64'h1);
      checkOutput("ch_en cleared in REQ", 64'(chEn), 64'h0);
      applyStimulus(0, 4'h0, 32'h0, 2'b00, 2'b00, 1); tick();
      checkOutput("dbg req low", 64'(dbgReq), 64'h0);
      checkOutput("dbg busy", 64'(busy), 64'h1);
      applyStimulus(0, 4'h0, 32'h0, 2'b00, 2'b00, 0); tick();
      checkOutput("idle after dbg busy", 64'(busy), 64'h0);
      applyStimulus(0, 4'h0, 32'h0, 2'b11, 2'b11, 0); tick();
      checkOutput("idle no req", 64'(dbgReq), 64'h0);

      // Match counter: write-wins, then countdown to the breaking pulse.
      applyStimulus(1, 4'h0, 32'h1, 2'b00, 2'b00, 0); tick();
      applyStimulus(1, 4'h1, 32'h2, 2'b00, 2'b00, 0); tick();
      checkOutput("cnt readback", 64'(cfgRdata), CNT_EN ? 64'h2 : 64'h0);
      if (CNT_EN) begin
         applyStimulus(1, 4'h1, 32'h5, 2'b01, 2'b00, 0); tick();
         checkOutput("cnt write wins", 64'(cfgRdata), 64'h5);
         checkOutput("cnt write wins req", 64'(dbgReq), 64'h0);
         applyStimulus(1, 4'h1, 32'h2, 2'b00, 2'b00, 0); tick();
      end
      breakAt = CNT_EN ? 2 : 0;
      for (int p = 0; p < 3; p++) begin
         applyStimulus(0, 4'h1, 32'h0, 2'b01, 2'b00, 0); tick();
         checkOutput($sformatf("cnt pulse%0d req", p), 64'(dbgReq), 64'(p == breakAt));
         checkOutput($sformatf("cnt pulse%0d cnt", p), 64'(cfgRdata),
                     (CNT_EN && p < 2) ? 64'(1 - p) : 64'h0);
         applyStimulus(0, 4'h1, 32'h0, 2'b00, 2'b00, 0);
         if (p == breakAt) break;
         tick();
      end
      applyStimulus(0, 4'h0, 32'h0, 2'b00, 2'b00, 1); tick();
      applyStimulus(0, 4'h0, 32'h0, 2'b00, 2'b00, 0); tick();

      // Asynchronous reset while requesting.
      applyStimulus(0, 4'h0, 32'h0, 2'b01, 2'b00, 0); tick();
      checkOutput("pre-reset req", 64'(dbgReq), 64'h1);
      applyStimulus(0, 4'h0, 32'h0, 2'b00, 2'b00, 0);
      #2 rst = 1'b1;
      #1;
      checkOutput("async reset req", 64'(dbgReq), 64'h0);
      checkOutput("async reset busy", 64'(busy), 64'h0);
      checkOutput("async reset ch_en", 64'(chEn), 64'h0);
      checkOutput("async reset ch_addr", 64'(chAddr), 64'h0);
      checkOutput("async reset ctrl", 64'(cfgRdata), 64'h0);
      cfgAddr = 4'h2;
      #1 checkOutput("async reset status", 64'(cfgRdata), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      modelReset();

      // Randomized run against the behavioural model.
      reqSeen = 0;
      for (int c = 0; c < 3000; c++) begin
         logic        w;
         logic [3:0]  a;
         logic [31:0] d;
         logic [1:0]  ih, mh;
         logic        dg;
         w  = ($urandom_range(0, 99) < 20);
         a  = addrPool[$urandom_range(0, 6)];
         d  = $urandom;
         if (a == 4'h1) d[7:0] = 8'($urandom_range(0, 3));
         ih = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
         mh = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
         if (mReq)      dg = ($urandom_range(0, 99) < 40);
         else if (mDbg) dg = ($urandom_range(0, 99) < 60);
         else           dg = ($urandom_range(0, 99) < 5);
         applyStimulus(w, a, d, ih, mh, dg);
         modelStep(w, a, d, ih, mh, dg);
         tick();
         if (mReq) reqSeen = 1;
         checkOutput($sformatf("rnd%0d req", c), 64'(dbgReq), 64'(mReq));
         checkOutput($sformatf("rnd%0d busy", c), 64'(busy), 64'(mReq || mDbg));
         checkOutput($sformatf("rnd%0d rdata@%0h", c, a), 64'(cfgRdata), 64'(modelRead(a)));
         checkOutput($sformatf("rnd%0d ch_en", c), 64'(chEn), 64'(mEn));
         checkOutput($sformatf("rnd%0d ch_type", c), 64'(chType), 64'(mTyp));
         checkOutput($sformatf("rnd%0d ch_addr", c), 64'(chAddr), {mAddr[1], mAddr[0]});
      end
      checkOutput("random run produced a request", 64'(reqSeen), 64'h1);

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule

// File: doc/had_bkpt_ctrl.md
# had_bkpt_ctrl

Breakpoint controller for the HAD debug unit. Holds configuration (compare address, enable, type) for up to NUM_CH breakpoint comparator channels and drives them. Collects their instruction-fetch and memory-access hit flags, applies an optional match counter, and sequences one debug-mode request to the core with a request/acknowledge handshake. Sits between the HAD register interface and the per-channel comparator units.

## Interface
- NUM_CH, 2: number of comparator channels, 1..8.
- CNT_W, 8: match-counter width.

- forever_cpuclk  in  1  core clock; all state on rising edge.
- hadrst  in  1  asynchronous, active-high reset.
- cfg_wen  in  1  register write strobe, single cycle.
- cfg_addr  in  4  register index.
- cfg_wdata  in  32  write data.
- cfg_rdata  out  32  read data for cfg_addr; combinational.
- ch_addr  out  NUM_CH*32  compare address per channel; channel i at [32i+31:32i].
- ch_en  out  NUM_CH  channel enable.
- ch_type  out  NUM_CH  0 = instruction breakpoint, 1 = memory watchpoint.
- ch_inst_hit  in  NUM_CH  per-channel instruction-match flag from comparator.
- ch_mem_hit  in  NUM_CH  per-channel retire-qualified memory-match flag.
- iu_yy_xx_dbgon  in  1  core is in debug mode; acts as request acknowledge.
- had_core_dbg_mode_req  out  1  debug-entry request to core; registered.
- bkpt_busy  out  1  high in REQ or DBG state.

## Operation
- Register map:
  - 0x0 CTRL: [NUM_CH-1:0] enables; [8+NUM_CH-1:8] types.
  - 0x1 CNT: [CNT_W-1:0].
  - 0x2 STATUS: [NUM_CH-1:0] sticky hit bits, write-1-to-clear; [18:16] HITID, read-only; [24] busy, read-only.
  - 0x4+i: channel i address.
  - Unmapped addresses read 0 and ignore writes.
- Qualified hit for channel i: ch_en[i] && (ch_type[i] ? ch_mem_hit[i] : ch_inst_hit[i]). Event = OR of all qualified hits.
- FSM:
  - IDLE: CTRL enables all zero. Goes to ARMED when any enable is set.
  - ARMED: on event with CNT==0 (and !iu_yy_xx_dbgon) → REQ. STATUS bits |= qualified-hit vector; HITID = lowest hitting index. On event with CNT!=0: CNT -= 1, stay ARMED, STATUS unchanged. All enables cleared → IDLE.
  - REQ: had_core_dbg_mode_req=1. When iu_yy_xx_dbgon=1 → DBG. Hits are ignored.
  - DBG: request low. When iu_yy_xx_dbgon falls → ARMED if any enable is set, else IDLE.
- Simultaneous inst and mem hits, or multiple channels hitting: one event, one decrement.
- A CNT write in the same cycle as a decrement: the write wins.
- A STATUS clear in the same cycle as a new set: the set wins for that bit.
- Config writes are accepted in every state. Clearing enables in REQ/DBG does not cancel the request; the exit decision is taken on leaving DBG.
- Event with iu_yy_xx_dbgon already high (debug entered from another source): ignored, no decrement.

## Timing
- Reset: all registers 0, state IDLE, had_core_dbg_mode_req=0, bkpt_busy=0, ch_en/ch_type/ch_addr=0.
- A write in cycle N is visible on ch_* outputs and on cfg_rdata at N+1.
- Event in cycle N → had_core_dbg_mode_req high from N+1, held until the cycle after dbgon is sampled high.
- STATUS and CNT update at N+1.
- Reset mid-request drops the request asynchronously.

## Configuration
- HAD_BKPT_CNT_EN defined: CNT register and decrement logic are present as above.
- Not defined: CNT reads 0 and writes are ignored; every event in ARMED breaks immediately.

## Structure
- Shared package had_bkpt_pkg holds:
  - register index constants (CTRL, CNT, STATUS, CH_BASE);
  - FSM state encoding (IDLE, ARMED, REQ, DBG);
  - STATUS field offsets.
- One sub-module: had_bkpt_prio_enc, a lowest-index priority encoder producing HITID from the hit vector.

## Test plan
- Write ch0 address 0x0000_1000, CTRL=0x01; pulse ch_inst_hit[0] → request high next cycle; STATUS=0x01, HITID=0; raise dbgon → request drops; lower dbgon → ARMED.
- CTRL=0x0303 (both channels mem type); pulse ch_mem_hit[1] and ch_mem_hit[0] together → STATUS=0x03, HITID=0, one request.
- HAD_BKPT_CNT_EN, CNT=2; three ch_inst_hit[0] pulses → CNT goes 1, then 0, and the third pulse breaks. Without the macro, the first pulse breaks.
- Channel 0 type=inst; pulse ch_mem_hit[0] only → no request, STATUS unchanged.
- In REQ, write CTRL=0; dbgon high then low → IDLE, bkpt_busy=0.
- Assert hadrst while in REQ → request 0 immediately, all registers 0.
